// File: rtl/dca_matrix_lsu_pkg.sv
// rtl/dca_matrix_lsu_pkg.sv - shared LSU instruction layout, op encodings, row widths and engine states
package dca_matrix_lsu_pkg;

   localparam int   BW_STRIDE    = 16;
   localparam int   BW_NUM_ROWS  = 8;
   localparam int   INST_OP_LSB   = 0;
   localparam int   INST_ADDR_LSB = 1;
   localparam logic OP_LOAD  = 1'b0;
   localparam logic OP_STORE = 1'b1;

   // Layout from bit 0 upward: op, addr, stride, num_rows.
   function automatic int inst_stride_lsb(input int bw_addr);
      return INST_ADDR_LSB + bw_addr;
   endfunction

   function automatic int inst_rows_lsb(input int bw_addr);
      return INST_ADDR_LSB + bw_addr + BW_STRIDE;
   endfunction

   function automatic int bw_inst(input int bw_addr);
      return INST_ADDR_LSB + bw_addr + BW_STRIDE + BW_NUM_ROWS;
   endfunction

   function automatic int bw_scalar(input int tensor_para);
      case (tensor_para)
         1:       return 32;
         2:       return 8;
         default: return 16;
      endcase
   endfunction

   function automatic int bw_tensor_row(input int matrix_size, input int tensor_para);
      return matrix_size * bw_scalar(tensor_para);
   endfunction

   typedef enum logic [2:0] {
      STATE_IDLE     = 3'd0,
      STATE_LD_ISSUE = 3'd1,
      STATE_LD_DRAIN = 3'd2,
      STATE_ST_XFER  = 3'd3,
      STATE_ST_DRAIN = 3'd4
   } lsu_state_e;

endpackage

// File: rtl/dca_matrix_lsu_row_buffer.sv
// rtl/dca_matrix_lsu_row_buffer.sv - two-entry FIFO holding load rows between memory and the matrix side
module dca_matrix_lsu_row_buffer #(
   parameter int BW_DATA = 128
) (
   input  logic               clk,
   input  logic               rstnn,
   input  logic               i_flush,
   input  logic               i_push,
   input  logic [BW_DATA-1:0] i_push_data,
   input  logic               i_pop,
   output logic               o_head_valid,
   output logic [BW_DATA-1:0] o_head_data,
   output logic [1:0]         o_occupancy
);

   logic [BW_DATA-1:0] r_data [2];
   logic               r_wptr;
   logic               r_rptr;
   logic [1:0]         r_count;

   // Flush wins over a same-cycle push so discarded read data never lands.
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         for (int i = 0; i < 2; i++) r_data[i] <= '0;
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else if (i_flush) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (i_push) begin
            r_data[r_wptr] <= i_push_data;
            r_wptr         <= ~r_wptr;
         end
         if (i_pop) r_rptr <= ~r_rptr;
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_head_valid = (r_count != 2'd0);
   assign o_head_data  = r_data[r_rptr];
   assign o_occupancy  = r_count;

endmodule

// File: rtl/dca_matrix_lsu_row_engine.sv
// rtl/dca_matrix_lsu_row_engine.sv - LSU row engine moving tensor rows between memory and the matrix unit
// Optional: DCA_MATRIX_LSU_ROW_ENGINE_STRIDE_EN uses the instruction stride instead of dense row spacing.
module dca_matrix_lsu_row_engine
   import dca_matrix_lsu_pkg::*;
#(
   parameter int  MATRIX_SIZE_PARA = 8,
   parameter int  TENSOR_PARA      = 0,
   parameter int  BW_ADDR          = 32,
   localparam int BW_TENSOR_ROW          = bw_tensor_row(MATRIX_SIZE_PARA, TENSOR_PARA),
   localparam int BW_DCA_MATRIX_LSU_INST = bw_inst(BW_ADDR)
) (
   input  logic                              clk,
   input  logic                              rstnn,
   input  logic                              clear,
   input  logic                              enable,
   output logic                              busy,
   output logic                              done,
   input  logic                              inst_valid,
   output logic                              inst_ready,
   input  logic [BW_DCA_MATRIX_LSU_INST-1:0] inst,
   input  logic                              load_tensor_row_wready,
   output logic                              load_tensor_row_wvalid,
   output logic                              load_tensor_row_wlast,
   output logic [BW_TENSOR_ROW-1:0]          load_tensor_row_wdata,
   output logic                              store_tensor_row_rvalid,
   input  logic                              store_tensor_row_rready,
   output logic                              store_tensor_row_rlast,
   input  logic [BW_TENSOR_ROW-1:0]          store_tensor_row_rdata,
   output logic                              mem_req,
   output logic                              mem_we,
   output logic [BW_ADDR-1:0]                mem_addr,
   output logic [BW_TENSOR_ROW-1:0]          mem_wdata,
   input  logic                              mem_ready,
   input  logic [BW_TENSOR_ROW-1:0]          mem_rdata
);

   localparam int                 STRIDE_LSB = inst_stride_lsb(BW_ADDR);
   localparam int                 ROWS_LSB   = inst_rows_lsb(BW_ADDR);
   localparam logic [BW_ADDR-1:0] STEP_DENSE = BW_ADDR'(BW_TENSOR_ROW / 8);

   lsu_state_e               r_state, w_state_next;
   logic [BW_ADDR-1:0]       r_addr, r_step, w_step;
   logic [BW_NUM_ROWS-1:0]   r_rows, r_req_cnt, r_out_cnt;
   logic                     r_inflight, r_zero_done, r_wb_valid;
   logic [BW_TENSOR_ROW-1:0] r_wb_data;

   logic                     w_inst_op;
   logic [BW_ADDR-1:0]       w_inst_addr;
   logic [BW_STRIDE-1:0]     w_inst_stride;
   logic [BW_NUM_ROWS-1:0]   w_inst_rows;
   logic w_hs, w_is_load, w_is_store, w_ld_req, w_st_req, w_rd_acc, w_wr_acc, w_pop, w_cap;
   logic                     w_head_valid;
   logic [1:0]               w_occ;

   assign w_inst_op     = inst[INST_OP_LSB];
   assign w_inst_addr   = inst[INST_ADDR_LSB +: BW_ADDR];
   assign w_inst_stride = inst[STRIDE_LSB +: BW_STRIDE];
   assign w_inst_rows   = inst[ROWS_LSB +: BW_NUM_ROWS];

`ifdef DCA_MATRIX_LSU_ROW_ENGINE_STRIDE_EN
   assign w_step = BW_ADDR'(w_inst_stride);
`else
   logic w_unused_stride;
   assign w_unused_stride = ^w_inst_stride;
   assign w_step          = STEP_DENSE;
`endif

   assign inst_ready = (r_state == STATE_IDLE) & enable;
   assign busy       = (r_state != STATE_IDLE);
   assign w_hs       = inst_valid & inst_ready;
   assign w_is_load  = (r_state == STATE_LD_ISSUE) | (r_state == STATE_LD_DRAIN);
   assign w_is_store = (r_state == STATE_ST_XFER)  | (r_state == STATE_ST_DRAIN);

   // Reads are throttled so every accepted read already owns a row-buffer slot.
   assign w_ld_req = (r_state == STATE_LD_ISSUE) & enable & ~clear
                   & ((w_occ + {1'b0, r_inflight}) < 2'd2);
   assign w_st_req = w_is_store & enable & ~clear & r_wb_valid;
   assign mem_req   = w_ld_req | w_st_req;
   assign mem_we    = w_st_req;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wb_data;
   assign w_rd_acc  = w_ld_req & mem_ready;
   assign w_wr_acc  = w_st_req & mem_ready;

   assign load_tensor_row_wvalid = w_is_load & enable & ~clear & w_head_valid;
   assign load_tensor_row_wlast  = load_tensor_row_wvalid & (r_out_cnt == r_rows - 8'd1);
   assign w_pop = load_tensor_row_wvalid & load_tensor_row_wready;

   // A write retiring this cycle frees the buffer for a back-to-back capture.
   assign store_tensor_row_rvalid = (r_state == STATE_ST_XFER) & enable & ~clear
                                  & (~r_wb_valid | w_wr_acc);
   assign store_tensor_row_rlast  = store_tensor_row_rvalid & (r_req_cnt == r_rows - 8'd1);
   assign w_cap = store_tensor_row_rvalid & store_tensor_row_rready;

   assign done = ~clear & (r_zero_done
                         | ((r_state == STATE_LD_DRAIN) & w_pop & load_tensor_row_wlast)
                         | ((r_state == STATE_ST_DRAIN) & w_wr_acc));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         STATE_IDLE:
            if (w_hs && (w_inst_rows != '0)) begin
               case (w_inst_op)
                  OP_LOAD:  w_state_next = STATE_LD_ISSUE;
                  OP_STORE: w_state_next = STATE_ST_XFER;
               endcase
            end
         STATE_LD_ISSUE: if (w_rd_acc && (r_req_cnt == r_rows - 8'd1)) w_state_next = STATE_LD_DRAIN;
         STATE_LD_DRAIN: if (w_pop && load_tensor_row_wlast) w_state_next = STATE_IDLE;
         STATE_ST_XFER:  if (w_cap && store_tensor_row_rlast) w_state_next = STATE_ST_DRAIN;
         STATE_ST_DRAIN: if (w_wr_acc) w_state_next = STATE_IDLE;
         default:        w_state_next = STATE_IDLE;
      endcase
      if (clear) w_state_next = STATE_IDLE;
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         r_state     <= STATE_IDLE;
         r_addr      <= '0;
         r_step      <= '0;
         r_rows      <= '0;
         r_req_cnt   <= '0;
         r_out_cnt   <= '0;
         r_inflight  <= 1'b0;
         r_zero_done <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_wb_data   <= '0;
      end else begin
         r_state <= w_state_next;
         if (clear) begin
            r_req_cnt   <= '0;
            r_out_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_zero_done <= 1'b0;
            r_wb_valid  <= 1'b0;
         end else begin
            r_zero_done <= w_hs & (w_inst_rows == '0);
            r_inflight  <= w_rd_acc;
            if (w_hs) begin
               r_addr    <= w_inst_addr;
               r_step    <= w_step;
               r_rows    <= w_inst_rows;
               r_req_cnt <= '0;
               r_out_cnt <= '0;
            end else begin
               if (w_rd_acc | w_wr_acc) r_addr <= r_addr + r_step;
               if (w_rd_acc | w_cap) r_req_cnt <= r_req_cnt + 8'd1;
               if (w_pop) r_out_cnt <= r_out_cnt + 8'd1;
            end
            if (w_cap) begin
               r_wb_valid <= 1'b1;
               r_wb_data  <= store_tensor_row_rdata;
            end else if (w_wr_acc) begin
               r_wb_valid <= 1'b0;
            end
         end
      end
   end

   dca_matrix_lsu_row_buffer #(
      .BW_DATA(BW_TENSOR_ROW)
   ) u_row_buffer (
      .clk         (clk),
      .rstnn       (rstnn),
      .i_flush     (clear),
      .i_push      (r_inflight),
      .i_push_data (mem_rdata),
      .i_pop       (w_pop),
      .o_head_valid(w_head_valid),
      .o_head_data (load_tensor_row_wdata),
      .o_occupancy (w_occ)
   );

endmodule

// File: doc/dca_matrix_lsu_row_engine.md
DCA_MATRIX_LSU_ROW_ENGINE -- requirements
Module: dca_matrix_lsu_row_engine

Interface
REQ-001 SHALL have parameter MATRIX_SIZE_PARA, default 8, selecting matrix dimension and so BW_TENSOR_ROW via the team's matrix/tensor dim lparas.
REQ-002 SHALL have parameter TENSOR_PARA, default 0, selecting tensor scalar type.
REQ-003 SHALL have parameter BW_ADDR, default 32, giving memory address width.
REQ-004 SHALL have ports, one per line (name direction width meaning):
 clk  in  1  single clock
 rstnn  in  1  asynchronous active-low reset
 clear  in  1  synchronous flush to IDLE
 enable  in  1  global advance enable
 busy  out  1  engine not IDLE
 done  out  1  one-cycle pulse on instruction retirement
 inst_valid  in  1  LSU instruction offered
 inst_ready  out  1  LSU instruction accepted
 inst  in  BW_DCA_MATRIX_LSU_INST  LSU instruction
 load_tensor_row_wready  in  1  matrix side accepts row
 load_tensor_row_wvalid  out  1  load row valid
 load_tensor_row_wlast  out  1  last row of instruction
 load_tensor_row_wdata  out  BW_TENSOR_ROW  load row
 store_tensor_row_rvalid  out  1  engine requests store row
 store_tensor_row_rready  in  1  matrix side presents row
 store_tensor_row_rlast  out  1  requested row is last
 store_tensor_row_rdata  in  BW_TENSOR_ROW  store row
 mem_req  out  1  memory request
 mem_we  out  1  1 write, 0 read
 mem_addr  out  BW_ADDR  row address
 mem_wdata  out  BW_TENSOR_ROW  write row
 mem_ready  in  1  request accepted this cycle
 mem_rdata  in  BW_TENSOR_ROW  read data, exactly 1 cycle after accepted read

Function
REQ-005 Instruction fields SHALL be: op (0 load, 1 store), addr (BW_ADDR), stride (16b, unsigned bytes), num_rows (0..MATRIX_SIZE).
REQ-006 inst_ready SHALL equal (state==IDLE) & enable; handshake = inst_valid & inst_ready; fields latched on handshake.
REQ-007 States SHALL be IDLE, LD_ISSUE, LD_DRAIN, ST_XFER, ST_DRAIN; busy = state!=IDLE.
REQ-008 num_rows==0 SHALL retire in the cycle after accept: done pulse, no memory or row traffic, stay IDLE.
REQ-009 LD_ISSUE: mem_req=1, mem_we=0 while row-buffer occupancy + in-flight < 2; address starts at addr, +step per accepted read, wrapping modulo 2^BW_ADDR.
REQ-010 Read data SHALL enter a 2-entry row buffer one cycle after acceptance; buffer head drives wvalid/wdata; wlast=1 exactly on the num_rows-th row.
REQ-011 LD_ISSUE->LD_DRAIN after last read accepted; LD_DRAIN->IDLE with done pulse on wvalid&wready&wlast.
REQ-012 ST_XFER: rvalid=1 while 1-entry write buffer empty and rows remain; rlast=1 on last requested row; rvalid&rready captures rdata into write buffer.
REQ-013 Write buffer valid SHALL drive mem_req=1, mem_we=1, mem_wdata; freed on mem_ready; capture and free allowed the same cycle (no bubble).
REQ-014 ST_XFER->ST_DRAIN after last row captured; ST_DRAIN->IDLE with done pulse on last write accepted.
REQ-015 enable=0 SHALL hold all state, drop mem_req, rvalid, wvalid; in-flight read data still captured.
REQ-016 clear SHALL, over enable, go IDLE, empty buffers, discard in-flight read data, suppress done.

Reset
REQ-017 On rstnn low: state IDLE, buffers empty, counters 0, all outputs 0; inst_ready=enable after release.

Configuration
REQ-018 DCA_MATRIX_LSU_ROW_ENGINE_STRIDE_EN defined: step=stride field; undefined: stride ignored, step=BW_TENSOR_ROW/8 bytes (dense rows).

Structure
REQ-019 Instruction field widths/offsets, op encodings and state encoding SHALL live in the shared dca_matrix_lsu package/header.
REQ-020 The 2-entry load row buffer SHALL be sub-module dca_matrix_lsu_row_buffer; remainder in this module.

Verification
REQ-021 Load addr=0x1000 stride=0x20 rows=4, wready=1, mem_ready=1 -> reads 0x1000,0x1020,0x1040,0x1060; 4 rows in order; wlast on 4th; done once.
REQ-022 Same load, wready=0 for 6 cycles -> at most 2 reads outstanding/buffered, no row lost or duplicated.
REQ-023 Store addr=0x2000 stride=0x40 rows=8, rready alternating -> 8 writes 0x2000..0x21C0 with matching data; rlast on 8th request.
REQ-024 rows=0 -> done pulse one cycle after accept, mem_req never asserted.
REQ-025 clear after 2nd read accepted -> IDLE next cycle, wvalid=0, late mem_rdata ignored, no done.
REQ-026 Macro undefined, MATRIX_SIZE_PARA=8, 16-bit scalars, stride=0x100 -> addresses step 0x10.
